mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_pick.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-requester memory bus arbiter.
//   - arb_state_e : transaction FSM encoding
//   - OWNER_M0/M1 : requester identifiers (grant_id values)
//   - DEF_ADDR_W / DEF_DATA_W : default channel widths
//   - other_owner : returns the opposite requester id
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 128;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } arb_state_e;

    function automatic logic other_owner(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way winner selection.
//   req_i[1:0]   : pending request per requester (bit N = mN)
//   last_owner_i : requester granted most recently (round-robin history)
//   rr_mode_i    : 1 = round-robin tie break, 0 = m0 always wins ties
//   winner_o     : selected requester id (meaningful only when req_i != 0)
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    input  logic       rr_mode_i,
    output logic       winner_o
);

    // Single requester wins outright; a tie goes to the non-last owner or to m0.
    always_comb begin
        winner_o = OWNER_M0;
        case (req_i)
            2'b01:   winner_o = OWNER_M0;
            2'b10:   winner_o = OWNER_M1;
            2'b11:   winner_o = rr_mode_i ? other_owner(last_owner_i) : OWNER_M0;
            default: winner_o = OWNER_M0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream AXI-Lite memory port (s_*) between two
// requesters (m0 = D-cache, m1). One transaction at a time, no interleaving.
//   clk, rst          : clock, synchronous active-high reset
//   m0_* / m1_*       : requester read-address, read-data, write-address,
//                       write-data and write-response channels
//   s_*               : downstream port, same channels with mirrored directions
//   grant_id          : current (or, when idle, last) owner
//   busy              : a transaction is in flight
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// without it m0 has fixed priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_readAddr_addr,
    input  logic                m0_readAddr_valid,
    output logic                m0_readAddr_ready,
    output logic [DATA_W-1:0]   m0_readData_data,
    output logic                m0_readData_valid,
    input  logic                m0_readData_ready,
    input  logic [ADDR_W-1:0]   m0_writeAddr_addr,
    input  logic                m0_writeAddr_valid,
    output logic                m0_writeAddr_ready,
    input  logic [DATA_W-1:0]   m0_writeData_data,
    input  logic [DATA_W/8-1:0] m0_writeData_strb,
    input  logic                m0_writeData_valid,
    output logic                m0_writeData_ready,
    output logic [31:0]         m0_writeResp_msg,
    output logic                m0_writeResp_valid,
    input  logic                m0_writeResp_ready,
    input  logic [ADDR_W-1:0]   m1_readAddr_addr,
    input  logic                m1_readAddr_valid,
    output logic                m1_readAddr_ready,
    output logic [DATA_W-1:0]   m1_readData_data,
    output logic                m1_readData_valid,
    input  logic                m1_readData_ready,
    input  logic [ADDR_W-1:0]   m1_writeAddr_addr,
    input  logic                m1_writeAddr_valid,
    output logic                m1_writeAddr_ready,
    input  logic [DATA_W-1:0]   m1_writeData_data,
    input  logic [DATA_W/8-1:0] m1_writeData_strb,
    input  logic                m1_writeData_valid,
    output logic                m1_writeData_ready,
    output logic [31:0]         m1_writeResp_msg,
    output logic                m1_writeResp_valid,
    input  logic                m1_writeResp_ready,
    output logic [ADDR_W-1:0]   s_readAddr_addr,
    output logic                s_readAddr_valid,
    input  logic                s_readAddr_ready,
    input  logic [DATA_W-1:0]   s_readData_data,
    input  logic                s_readData_valid,
    output logic                s_readData_ready,
    output logic [ADDR_W-1:0]   s_writeAddr_addr,
    output logic                s_writeAddr_valid,
    input  logic                s_writeAddr_ready,
    output logic [DATA_W-1:0]   s_writeData_data,
    output logic [DATA_W/8-1:0] s_writeData_strb,
    output logic                s_writeData_valid,
    input  logic                s_writeData_ready,
    input  logic [31:0]         s_writeResp_msg,
    input  logic                s_writeResp_valid,
    output logic                s_writeResp_ready,
    output logic                grant_id,
    output logic                busy
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic RR_MODE = 1'b1;
`else
    localparam logic RR_MODE = 1'b0;
`endif

    arb_state_e state_q;
    logic       owner_q;
    logic       rr_last_q;
    logic       aw_done_q;
    logic       w_done_q;

    logic [1:0] req_s;
    logic       winner_s;
    logic       win_wr_s;
    logic       own_m0_s;
    logic       ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;

    // Owner-selected requester inputs
    logic [ADDR_W-1:0]   own_ar_addr_s, own_aw_addr_s;
    logic [DATA_W-1:0]   own_w_data_s;
    logic [DATA_W/8-1:0] own_w_strb_s;
    logic                own_ar_valid_s, own_r_ready_s, own_aw_valid_s, own_w_valid_s, own_b_ready_s;

    // Downstream responses destined for the owner
    logic [DATA_W-1:0]   to_r_data_s;
    logic [31:0]         to_b_msg_s;
    logic                to_ar_ready_s, to_r_valid_s, to_aw_ready_s, to_w_ready_s, to_b_valid_s;

    // Pending = either address channel valid; the decision uses only requester
    // valids and registered state, never downstream readies.
    assign req_s    = {m1_readAddr_valid | m1_writeAddr_valid,
                       m0_readAddr_valid | m0_writeAddr_valid};
    assign win_wr_s = (winner_s == OWNER_M1) ? m1_writeAddr_valid : m0_writeAddr_valid;

    arb_pick u_pick (
        .req_i        (req_s),
        .last_owner_i (rr_last_q),
        .rr_mode_i    (RR_MODE),
        .winner_o     (winner_s)
    );

    assign own_m0_s       = (owner_q == OWNER_M0);
    assign own_ar_addr_s  = own_m0_s ? m0_readAddr_addr   : m1_readAddr_addr;
    assign own_ar_valid_s = own_m0_s ? m0_readAddr_valid  : m1_readAddr_valid;
    assign own_r_ready_s  = own_m0_s ? m0_readData_ready  : m1_readData_ready;
    assign own_aw_addr_s  = own_m0_s ? m0_writeAddr_addr  : m1_writeAddr_addr;
    assign own_aw_valid_s = own_m0_s ? m0_writeAddr_valid : m1_writeAddr_valid;
    assign own_w_data_s   = own_m0_s ? m0_writeData_data  : m1_writeData_data;
    assign own_w_strb_s   = own_m0_s ? m0_writeData_strb  : m1_writeData_strb;
    assign own_w_valid_s  = own_m0_s ? m0_writeData_valid : m1_writeData_valid;
    assign own_b_ready_s  = own_m0_s ? m0_writeResp_ready : m1_writeResp_ready;

    // Channel routing between the owner and the downstream port per FSM state
    always_comb begin
        s_readAddr_addr   = {ADDR_W{1'b0}};
        s_readAddr_valid  = 1'b0;
        s_readData_ready  = 1'b0;
        s_writeAddr_addr  = {ADDR_W{1'b0}};
        s_writeAddr_valid = 1'b0;
        s_writeData_data  = {DATA_W{1'b0}};
        s_writeData_strb  = {(DATA_W/8){1'b0}};
        s_writeData_valid = 1'b0;
        s_writeResp_ready = 1'b0;
        to_ar_ready_s     = 1'b0;
        to_r_data_s       = {DATA_W{1'b0}};
        to_r_valid_s      = 1'b0;
        to_aw_ready_s     = 1'b0;
        to_w_ready_s      = 1'b0;
        to_b_msg_s        = 32'h0000_0000;
        to_b_valid_s      = 1'b0;
        case (state_q)
            ST_RD_ADDR: begin
                s_readAddr_addr  = own_ar_addr_s;
                s_readAddr_valid = own_ar_valid_s;
                to_ar_ready_s    = s_readAddr_ready;
            end
            ST_RD_DATA: begin
                to_r_data_s      = s_readData_data;
                to_r_valid_s     = s_readData_valid;
                s_readData_ready = own_r_ready_s;
            end
            ST_WR_REQ: begin
                // A channel that already handshook is masked so it cannot repeat
                s_writeAddr_addr  = own_aw_addr_s;
                s_writeAddr_valid = own_aw_valid_s & ~aw_done_q;
                to_aw_ready_s     = s_writeAddr_ready & ~aw_done_q;
                s_writeData_data  = own_w_data_s;
                s_writeData_strb  = own_w_strb_s;
                s_writeData_valid = own_w_valid_s & ~w_done_q;
                to_w_ready_s      = s_writeData_ready & ~w_done_q;
            end
            ST_WR_RESP: begin
                to_b_msg_s        = s_writeResp_msg;
                to_b_valid_s      = s_writeResp_valid;
                s_writeResp_ready = own_b_ready_s;
            end
            default: begin
                s_readAddr_valid = 1'b0;
            end
        endcase
    end

    assign ar_hs_s = s_readAddr_valid  & s_readAddr_ready;
    assign r_hs_s  = s_readData_valid  & s_readData_ready;
    assign aw_hs_s = s_writeAddr_valid & s_writeAddr_ready;
    assign w_hs_s  = s_writeData_valid & s_writeData_ready;
    assign b_hs_s  = s_writeResp_valid & s_writeResp_ready;

    // Fan owner-bound signals out; the non-owner sees zeros throughout
    assign m0_readAddr_ready  = own_m0_s  & to_ar_ready_s;
    assign m1_readAddr_ready  = ~own_m0_s & to_ar_ready_s;
    assign m0_readData_data   = own_m0_s  ? to_r_data_s : {DATA_W{1'b0}};
    assign m1_readData_data   = ~own_m0_s ? to_r_data_s : {DATA_W{1'b0}};
    assign m0_readData_valid  = own_m0_s  & to_r_valid_s;
    assign m1_readData_valid  = ~own_m0_s & to_r_valid_s;
    assign m0_writeAddr_ready = own_m0_s  & to_aw_ready_s;
    assign m1_writeAddr_ready = ~own_m0_s & to_aw_ready_s;
    assign m0_writeData_ready = own_m0_s  & to_w_ready_s;
    assign m1_writeData_ready = ~own_m0_s & to_w_ready_s;
    assign m0_writeResp_msg   = own_m0_s  ? to_b_msg_s : 32'h0000_0000;
    assign m1_writeResp_msg   = ~own_m0_s ? to_b_msg_s : 32'h0000_0000;
    assign m0_writeResp_valid = own_m0_s  & to_b_valid_s;
    assign m1_writeResp_valid = ~own_m0_s & to_b_valid_s;

    assign grant_id = owner_q;
    assign busy     = (state_q != ST_IDLE);

    // Transaction FSM: grant, per-channel write completion, return to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_M0;
            rr_last_q <= OWNER_M1;  // so the first tie after reset goes to m0
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s != 2'b00) begin
                        owner_q   <= winner_s;
                        rr_last_q <= winner_s;
                        // Write before read from the same requester
                        state_q   <= win_wr_s ? ST_WR_REQ : ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (ar_hs_s) state_q <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (r_hs_s) state_q <= ST_IDLE;
                end
                ST_WR_REQ: begin
                    if (aw_hs_s) aw_done_q <= 1'b1;
                    if (w_hs_s)  w_done_q  <= 1'b1;
                    if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) state_q <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (b_hs_s) begin
                        state_q   <= ST_IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: per-cycle vector table plus a starvation /
// round-robin sequence over four back-to-back reads.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    localparam logic [AW-1:0] M0_RA = 32'h0000_1230;
    localparam logic [AW-1:0] M1_RA = 32'h0000_2000;
    localparam logic [AW-1:0] M0_WA = 32'h0000_0080;
    localparam logic [AW-1:0] M1_WA = 32'h0000_0040;
    localparam logic [DW-1:0] LINE  = {16{8'hA5}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_readAddr_addr, m1_readAddr_addr, m0_writeAddr_addr, m1_writeAddr_addr;
    logic m0_readAddr_valid, m0_readAddr_ready, m1_readAddr_valid, m1_readAddr_ready;
    logic [DW-1:0] m0_readData_data, m1_readData_data, m0_writeData_data, m1_writeData_data;
    logic m0_readData_valid, m0_readData_ready, m1_readData_valid, m1_readData_ready;
    logic m0_writeAddr_valid, m0_writeAddr_ready, m1_writeAddr_valid, m1_writeAddr_ready;
    logic [SW-1:0] m0_writeData_strb, m1_writeData_strb, s_writeData_strb;
    logic m0_writeData_valid, m0_writeData_ready, m1_writeData_valid, m1_writeData_ready;
    logic [31:0] m0_writeResp_msg, m1_writeResp_msg, s_writeResp_msg;
    logic m0_writeResp_valid, m0_writeResp_ready, m1_writeResp_valid, m1_writeResp_ready;
    logic [AW-1:0] s_readAddr_addr, s_writeAddr_addr;
    logic s_readAddr_valid, s_readAddr_ready, s_readData_valid, s_readData_ready;
    logic [DW-1:0] s_readData_data, s_writeData_data;
    logic s_writeAddr_valid, s_writeAddr_ready, s_writeData_valid, s_writeData_ready;
    logic s_writeResp_valid, s_writeResp_ready, grant_id, busy;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_readAddr_addr(m0_readAddr_addr), .m0_readAddr_valid(m0_readAddr_valid),
        .m0_readAddr_ready(m0_readAddr_ready), .m0_readData_data(m0_readData_data),
        .m0_readData_valid(m0_readData_valid), .m0_readData_ready(m0_readData_ready),
        .m0_writeAddr_addr(m0_writeAddr_addr), .m0_writeAddr_valid(m0_writeAddr_valid),
        .m0_writeAddr_ready(m0_writeAddr_ready), .m0_writeData_data(m0_writeData_data),
        .m0_writeData_strb(m0_writeData_strb), .m0_writeData_valid(m0_writeData_valid),
        .m0_writeData_ready(m0_writeData_ready), .m0_writeResp_msg(m0_writeResp_msg),
        .m0_writeResp_valid(m0_writeResp_valid), .m0_writeResp_ready(m0_writeResp_ready),
        .m1_readAddr_addr(m1_readAddr_addr), .m1_readAddr_valid(m1_readAddr_valid),
        .m1_readAddr_ready(m1_readAddr_ready), .m1_readData_data(m1_readData_data),
        .m1_readData_valid(m1_readData_valid), .m1_readData_ready(m1_readData_ready),
        .m1_writeAddr_addr(m1_writeAddr_addr), .m1_writeAddr_valid(m1_writeAddr_valid),
        .m1_writeAddr_ready(m1_writeAddr_ready), .m1_writeData_data(m1_writeData_data),
        .m1_writeData_strb(m1_writeData_strb), .m1_writeData_valid(m1_writeData_valid),
        .m1_writeData_ready(m1_writeData_ready), .m1_writeResp_msg(m1_writeResp_msg),
        .m1_writeResp_valid(m1_writeResp_valid), .m1_writeResp_ready(m1_writeResp_ready),
        .s_readAddr_addr(s_readAddr_addr), .s_readAddr_valid(s_readAddr_valid),
        .s_readAddr_ready(s_readAddr_ready), .s_readData_data(s_readData_data),
        .s_readData_valid(s_readData_valid), .s_readData_ready(s_readData_ready),
        .s_writeAddr_addr(s_writeAddr_addr), .s_writeAddr_valid(s_writeAddr_valid),
        .s_writeAddr_ready(s_writeAddr_ready), .s_writeData_data(s_writeData_data),
        .s_writeData_strb(s_writeData_strb), .s_writeData_valid(s_writeData_valid),
        .s_writeData_ready(s_writeData_ready), .s_writeResp_msg(s_writeResp_msg),
        .s_writeResp_valid(s_writeResp_valid), .s_writeResp_ready(s_writeResp_ready),
        .grant_id(grant_id), .busy(busy)
    );

    // in  = {rst | m0 rv,awv,wv,rdrdy | m1 rv,awv,wv,rdrdy | s arrdy,rv,awrdy,wrdy,bv}
    // exp = {busy,gid | s_arv,m0_arrdy,m1_arrdy | m0_rv,m1_rv | s_awv,s_wv,m1_awrdy | m0_bv,m1_bv}
    typedef struct {
        string       nm;
        logic [13:0] in;
        logic [11:0] exp;
        logic [31:0] ara;
        logic [31:0] awa;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(string nm, logic [13:0] in, logic [11:0] exp,
                                logic [31:0] ara, logic [31:0] awa);
        vec_t v;
        v.nm = nm; v.in = in; v.exp = exp; v.ara = ara; v.awa = awa;
        return v;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic drive(logic [13:0] in);
        rst                = in[13];
        m0_readAddr_valid  = in[12];
        m0_writeAddr_valid = in[11];
        m0_writeData_valid = in[10];
        m0_readData_ready  = in[9];
        m1_readAddr_valid  = in[8];
        m1_writeAddr_valid = in[7];
        m1_writeData_valid = in[6];
        m1_readData_ready  = in[5];
        s_readAddr_ready   = in[4];
        s_readData_valid   = in[3];
        s_writeAddr_ready  = in[2];
        s_writeData_ready  = in[1];
        s_writeResp_valid  = in[0];
    endtask

    initial begin
        logic [11:0] got;
        logic [DW-1:0] exp_d;
        int n;
        m0_readAddr_addr  = M0_RA;  m1_readAddr_addr  = M1_RA;
        m0_writeAddr_addr = M0_WA;  m1_writeAddr_addr = M1_WA;
        m0_writeData_data = {16{8'h11}}; m1_writeData_data = {16{8'h22}};
        m0_writeData_strb = 16'hFFFF;    m1_writeData_strb = 16'h000F;
        m0_writeResp_ready = 1'b1;       m1_writeResp_ready = 1'b1;
        s_readData_data   = LINE;
        s_writeResp_msg   = 32'h0000_0000;
        drive(14'b1_0000_0000_00000);
        repeat (2) @(posedge clk);

        // m0 read alone, 5-cycle read-data stall
        vecs.push_back(mk("rst_state",  14'b0_0000_0000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m0_rd_req",  14'b0_1000_0000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m0_ar_wait", 14'b0_1000_0000_00000, 12'b10_100_00_000_00, M0_RA, 32'h0));
        vecs.push_back(mk("m0_ar_hs",   14'b0_1000_0000_10000, 12'b10_110_00_000_00, M0_RA, 32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("m0_r_stall", 14'b0_0000_0000_01000, 12'b10_000_10_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m0_r_take",  14'b0_0001_0000_01000, 12'b10_000_10_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("idle_a",     14'b0_0000_0000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        // m1 write, W accepted 3 cycles after AW
        vecs.push_back(mk("m1_wr_req",  14'b0_0000_0110_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m1_aw_hs",   14'b0_0000_0110_00100, 12'b11_000_00_111_00, 32'h0, M1_WA));
        vecs.push_back(mk("m1_w_wait1", 14'b0_0000_0010_00100, 12'b11_000_00_010_00, 32'h0, M1_WA));
        vecs.push_back(mk("m1_w_wait2", 14'b0_0000_0010_00100, 12'b11_000_00_010_00, 32'h0, M1_WA));
        vecs.push_back(mk("m1_w_hs",    14'b0_0000_0010_00110, 12'b11_000_00_010_00, 32'h0, M1_WA));
        vecs.push_back(mk("m1_b",       14'b0_0000_0000_00001, 12'b11_000_00_000_01, 32'h0, 32'h0));
        vecs.push_back(mk("idle_b",     14'b0_0000_0000_00000, 12'b01_000_00_000_00, 32'h0, 32'h0));
        // m0 read+write together: write first
        vecs.push_back(mk("m0_rw_req",  14'b0_1110_0000_00000, 12'b01_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m0_wr_hs",   14'b0_1110_0000_00110, 12'b10_000_00_110_00, 32'h0, M0_WA));
        vecs.push_back(mk("m0_b",       14'b0_1000_0000_00001, 12'b10_000_00_000_10, 32'h0, 32'h0));
        vecs.push_back(mk("m0_rd_next", 14'b0_1000_0000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m0_ar2",     14'b0_1000_0000_10000, 12'b10_110_00_000_00, M0_RA, 32'h0));
        vecs.push_back(mk("m0_r2",      14'b0_0001_0000_01000, 12'b10_000_10_000_00, 32'h0, 32'h0));
        // reset during m1 read data, then m1 again
        vecs.push_back(mk("m1_rd_req",  14'b0_0000_1000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m1_ar_hs",   14'b0_0000_1000_10000, 12'b11_101_00_000_00, M1_RA, 32'h0));
        vecs.push_back(mk("rst_in_rd",  14'b1_0000_0000_01000, 12'b11_000_01_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("after_rst",  14'b0_0000_0000_01000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m1_req2",    14'b0_0000_1000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("m1_ar2",     14'b0_0000_1000_10000, 12'b11_101_00_000_00, M1_RA, 32'h0));
        vecs.push_back(mk("m1_r2",      14'b0_0000_0001_01000, 12'b11_000_01_000_00, 32'h0, 32'h0));
        // tie after reset: m0 first in either mode, m1 held and served next
        vecs.push_back(mk("rst_tie",    14'b1_0000_0000_00000, 12'b01_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("tie_req",    14'b0_1000_1000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("tie_ar_m0",  14'b0_1000_1000_10000, 12'b10_110_00_000_00, M0_RA, 32'h0));
        vecs.push_back(mk("tie_r_m0",   14'b0_0001_1000_01000, 12'b10_000_10_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("tie_m1",     14'b0_0000_1000_00000, 12'b00_000_00_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("tie_ar_m1",  14'b0_0000_1000_10000, 12'b11_101_00_000_00, M1_RA, 32'h0));
        vecs.push_back(mk("tie_r_m1",   14'b0_0000_0001_01000, 12'b11_000_01_000_00, 32'h0, 32'h0));
        vecs.push_back(mk("final_idle", 14'b0_0000_0000_00000, 12'b01_000_00_000_00, 32'h0, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in);
            #1;
            got = {busy, grant_id, s_readAddr_valid, m0_readAddr_ready, m1_readAddr_ready,
                   m0_readData_valid, m1_readData_valid, s_writeAddr_valid, s_writeData_valid,
                   m1_writeAddr_ready, m0_writeResp_valid, m1_writeResp_valid};
            chk({vecs[i].nm, ".ctl"},    128'(got), 128'(vecs[i].exp));
            chk({vecs[i].nm, ".araddr"}, 128'(s_readAddr_addr), 128'(vecs[i].ara));
            chk({vecs[i].nm, ".awaddr"}, 128'(s_writeAddr_addr), 128'(vecs[i].awa));
            exp_d = vecs[i].exp[6] ? LINE : {DW{1'b0}};
            chk({vecs[i].nm, ".m0data"}, m0_readData_data, exp_d);
            exp_d = vecs[i].exp[5] ? LINE : {DW{1'b0}};
            chk({vecs[i].nm, ".m1data"}, m1_readData_data, exp_d);
            if (vecs[i].exp[0]) begin
                chk({vecs[i].nm, ".m1msg"}, 128'(m1_writeResp_msg), 128'h0);
                chk({vecs[i].nm, ".m1strb_idle"}, 128'(s_writeData_strb), 128'h0);
            end
            if (vecs[i].nm == "m1_aw_hs")
                chk("m1_aw_hs.strb", 128'(s_writeData_strb), 128'h000F);
        end

        // Both requesters continuously re-requesting reads: four grants
        @(negedge clk);
        drive(14'b1_0000_0000_00000);
        @(negedge clk);
        drive(14'b0_1001_1001_11000);
        for (int t = 0; t < 4; t++) begin
            logic exp_g;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = t[0];
`else
            exp_g = 1'b0;
`endif
            n = 0;
            #1;
            while (busy !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
            total++;
            if (n >= 20) begin
                bad++;
                $display("FAIL starve_wait%0d: busy never rose within 20 cycles", t);
            end else begin
                chk($sformatf("starve_grant%0d", t), 128'(grant_id), 128'(exp_g));
            end
            n = 0;
            while (busy !== 1'b0 && n < 20) begin @(negedge clk); #1; n++; end
            total++;
            if (n >= 20) begin
                bad++;
                $display("FAIL starve_done%0d: busy never fell within 20 cycles", t);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
